pool_buf_reader: RTL and testbench
==================================

// Module: pool_buf_reader
// PURPOSE
//  Read-side master for the pooled-feature-map BRAM in the accumulate/pool stage.
//  Waits until the selected pool lanes have all pulsed pool_last, then issues
//  rden/rdptr to the SA data BRAM. Streams the returned bytes out on a
//  valid/ready channel that feeds the next layer's ifmap loader.
// PARAMETERS
//  ADDR_W   14  BRAM read address width (sa_data_rdptr)
//  DATA_W    8  BRAM read data width
//  LANES    16  number of pool_last lanes
//  PA_W     10  pool-address BRAM data width (used only with POOL_RD_ADDR_EN)
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       async active-low reset
//  start_i        in   1       launch a transfer; sampled only in IDLE
//  base_addr_i    in   ADDR_W  first BRAM address; captured on start
//  len_i          in   ADDR_W  number of bytes to read; captured on start
//  lane_mask_i    in   LANES   pool lanes that must finish; captured on start
//  pool_last_i    in   LANES   per-lane done pulses from the pool stage
//  rden_o         out  1       BRAM read enable
//  rdptr_o        out  ADDR_W  BRAM read address
//  rdata_i        in   DATA_W  BRAM data, valid 1 cycle after rden_o
//  pa_rdata_i     in   PA_W    pool-address BRAM data (POOL_RD_ADDR_EN only)
//  m_valid_o      out  1       output beat valid
//  m_ready_i      in   1       downstream ready
//  m_data_o       out  DATA_W  output byte
//  m_addr_o       out  PA_W    pool address of the beat (POOL_RD_ADDR_EN only)
//  m_last_o       out  1       last beat of the transfer
//  busy_o         out  1       state != IDLE
//  done_o         out  1       1-cycle pulse after the last handshake
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0. Sticky lane register, counters and skid FIFO are cleared.
//  Sticky reg: sticky |= pool_last_i every cycle; cleared when done_o fires.
//  FSM states: IDLE, WAIT, READ, DRAIN.
//   IDLE -start_i-> WAIT. Captures base, len and mask. start_i in any other state is ignored.
//   WAIT: when (sticky & mask) == mask, go to READ (or to DRAIN if len == 0).
//     A mask of 0 passes immediately.
//   READ: issue one read per cycle while credit allows. After len reads, go to DRAIN.
//   DRAIN: when the FIFO is empty and nothing is in flight, pulse done_o and go to IDLE.
//  Credit rule: issue when (fifo_cnt + inflight - pop) < 2, where pop = m_valid_o & m_ready_i.
//   This sustains 1 beat/cycle with m_ready_i held at 1.
//  Latency: rden_o at cycle t; data is written to the FIFO at t+1; m_valid_o is asserted at t+2.
//  Address: rdptr_o = base + issued_cnt, modulo 2^ADDR_W (wraps from 16383 to 0).
//  m_last_o is asserted with beat number len-1. The beat holds stable while m_valid_o & !m_ready_i.
//  len == 0: no reads are issued and m_valid_o never rises. done_o pulses 1 cycle after
//   entering DRAIN.
//  pool_last_i in the same cycle as the sticky clear: the new pulse is kept (set wins over clear).
//  Async reset mid-transfer aborts immediately; in-flight BRAM data is discarded.
// CONFIGURATION
//  POOL_RD_ADDR_EN defined:
//   - pa_rdata_i is captured in the same cycle as rdata_i.
//   - The FIFO entry widens to DATA_W+PA_W, and m_addr_o carries the pool address of each beat.
//   - The pool-address BRAM is driven by rden_o/rdptr_o.
//  POOL_RD_ADDR_EN undefined: pa_rdata_i is ignored and m_addr_o is tied to 0.
// STRUCTURE
//  acpo_pkg:
//   - ADDR_W/DATA_W/PA_W/LANES constants
//   - typedef enum logic [1:0] {IDLE,WAIT,READ,DRAIN} prd_state_e
//   - typedef of the FIFO entry struct {data, addr, last}
//  Sub-module pool_rd_skid:
//   - 2-entry FIFO (push, pop, cnt, full, empty)
//   - Parameterised on entry width
// TESTING
//  T1 base=0x0100, len=4, mask=0xFFFF, all lanes pulsed before start, ready=1:
//   - rdptr 0x100..0x103 on 4 consecutive cycles
//   - 4 beats back-to-back, last on the 4th, then done_o
//  T2 mask=0x0003, lane0 pulses, lane1 pulses 10 cycles later:
//   - rden_o stays 0 until the cycle after lane1's pulse is registered
//  T3 len=6, m_ready_i toggles 1,0,0,1...:
//   - no beat lost or duplicated
//   - data order matches BRAM model
//   - rden_o never has more than 2 outstanding entries
//  T4 base=0x3FFE, len=4: rdptr sequence is 0x3FFE, 0x3FFF, 0x0000, 0x0001
//  T5 len=0: no rden_o and no m_valid_o; done_o pulses once; busy_o returns to 0
//  T6 rst_n low mid-READ: all outputs are 0 immediately; a new start after release runs cleanly

Source files
------------

// File: rtl/acpo_pkg.sv
// Shared constants and types for the pooled-feature-map read master.
// POOL_RD_ADDR_EN adds a pool-address field to each skid entry.
package acpo_pkg;

   localparam int PRD_ADDR_W = 14;
   localparam int PRD_DATA_W = 8;
   localparam int PRD_LANES  = 16;
   localparam int PRD_PA_W   = 10;

   typedef enum logic [1:0] {IDLE, WAIT, READ, DRAIN} prd_state_e;

`ifdef POOL_RD_ADDR_EN
   typedef struct packed {
      logic [PRD_DATA_W-1:0] data;
      logic [PRD_PA_W-1:0]   addr;
      logic                  last;
   } prd_entry_t;
`else
   typedef struct packed {
      logic [PRD_DATA_W-1:0] data;
      logic                  last;
   } prd_entry_t;
`endif

   localparam int PRD_ENTRY_W = $bits(prd_entry_t);

endpackage

// File: rtl/pool_rd_skid.sv
// Two-entry skid FIFO absorbing BRAM read latency between issue and the output channel.
// Simultaneous push and pop are allowed even when full.
module pool_rd_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   cnt,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt      <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries no control meaning, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (cnt == 2'd2);
   assign empty = (cnt == 2'd0);

endmodule

// File: rtl/pool_buf_reader.sv
// Pooled-feature-map BRAM read master: waits on the selected pool lanes, then streams bytes out.
// Define POOL_RD_ADDR_EN to carry the pool-address BRAM word alongside each beat on m_addr_o.
module pool_buf_reader
   import acpo_pkg::*;
#(
   parameter int ADDR_W = PRD_ADDR_W,
   parameter int DATA_W = PRD_DATA_W,
   parameter int LANES  = PRD_LANES,
   parameter int PA_W   = PRD_PA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W-1:0] len_i,
   input  logic [LANES-1:0]  lane_mask_i,
   input  logic [LANES-1:0]  pool_last_i,
   output logic              rden_o,
   output logic [ADDR_W-1:0] rdptr_o,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [PA_W-1:0]   pa_rdata_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DATA_W-1:0] m_data_o,
   output logic [PA_W-1:0]   m_addr_o,
   output logic              m_last_o,
   output logic              busy_o,
   output logic              done_o
);

   prd_state_e        state_q, state_d;
   logic [LANES-1:0]  sticky_q;
   logic [LANES-1:0]  mask_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] issued_q;

   logic              issue;
   logic              issue_last;
   logic              pop;
   logic              done;
   logic [2:0]        occ;

   logic              vld_p1;
   logic              last_p1;

   logic [1:0]        fifo_cnt;
   logic              fifo_full;
   logic              fifo_empty;
   prd_entry_t        push_ent;
   prd_entry_t        head_ent;

   assign pop        = m_valid_o & m_ready_i;
   assign issue_last = (issued_q == len_q - ADDR_W'(1));
   // Occupancy the FIFO will hold next cycle once the in-flight read lands.
   assign occ        = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, pop};

   // State register and control counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sticky_q <= '0;
         mask_q   <= '0;
         base_q   <= '0;
         len_q    <= '0;
         issued_q <= '0;
         vld_p1   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sticky_q <= (done ? '0 : sticky_q) | pool_last_i;
         vld_p1   <= issue;
         if (state_q == IDLE && start_i) begin
            base_q   <= base_addr_i;
            len_q    <= len_i;
            mask_q   <= lane_mask_i;
            issued_q <= '0;
         end else if (issue) begin
            issued_q <= issued_q + ADDR_W'(1);
         end
      end
   end

   // Stage p1: read data returns from the BRAM
   always_ff @(posedge clk) begin
      last_p1 <= issue_last;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start_i) state_d = WAIT;
         WAIT:  if ((sticky_q & mask_q) == mask_q)
                   state_d = (len_q == '0) ? DRAIN : READ;
         READ:  if (issue && issue_last) state_d = DRAIN;
         DRAIN: if (fifo_empty && !vld_p1) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      issue   = (state_q == READ) && (occ < 3'd2);
      done    = (state_q == DRAIN) && fifo_empty && !vld_p1;
      rden_o  = issue;
      rdptr_o = issue ? (base_q + issued_q) : '0;
      busy_o  = (state_q != IDLE);
      done_o  = done;
   end

   always_comb begin
      push_ent      = '0;
      push_ent.data = rdata_i;
      push_ent.last = last_p1;
`ifdef POOL_RD_ADDR_EN
      push_ent.addr = pa_rdata_i;
`endif
   end

   // Stage p2: beat presented from the skid FIFO
   pool_rd_skid #(
      .W(PRD_ENTRY_W)
   ) u_skid (
      .clk  (clk),
      .rst_n(rst_n),
      .push (vld_p1),
      .din  (push_ent),
      .pop  (pop),
      .dout (head_ent),
      .cnt  (fifo_cnt),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   assign m_valid_o = !fifo_empty;
   assign m_data_o  = fifo_empty ? '0 : head_ent.data;
   assign m_last_o  = !fifo_empty && head_ent.last;

`ifdef POOL_RD_ADDR_EN
   assign m_addr_o = fifo_empty ? '0 : head_ent.addr;
   logic unused_full;
   assign unused_full = fifo_full;
`else
   assign m_addr_o = '0;
   logic unused_pa;
   assign unused_pa = fifo_full ^ (^pa_rdata_i);
`endif

endmodule

// File: tb/tb_pool_buf_reader.sv
// Directed bench for pool_buf_reader with a BRAM model and a beat/address scoreboard.
module tb_pool_buf_reader;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;
   localparam int LANES  = 16;
   localparam int PA_W   = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start_i;
   logic [ADDR_W-1:0] base_addr_i;
   logic [ADDR_W-1:0] len_i;
   logic [LANES-1:0]  lane_mask_i;
   logic [LANES-1:0]  pool_last_i;
   logic              rden_o;
   logic [ADDR_W-1:0] rdptr_o;
   logic [DATA_W-1:0] rdata_i;
   logic [PA_W-1:0]   pa_rdata_i;
   logic              m_valid_o;
   logic              m_ready_i;
   logic [DATA_W-1:0] m_data_o;
   logic [PA_W-1:0]   m_addr_o;
   logic              m_last_o;
   logic              busy_o;
   logic              done_o;

   pool_buf_reader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .base_addr_i(base_addr_i),
      .len_i      (len_i),
      .lane_mask_i(lane_mask_i),
      .pool_last_i(pool_last_i),
      .rden_o     (rden_o),
      .rdptr_o    (rdptr_o),
      .rdata_i    (rdata_i),
      .pa_rdata_i (pa_rdata_i),
      .m_valid_o  (m_valid_o),
      .m_ready_i  (m_ready_i),
      .m_data_o   (m_data_o),
      .m_addr_o   (m_addr_o),
      .m_last_o   (m_last_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [PA_W-1:0]   addr;
      logic              last;
   } beat_t;

   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          iss_tot = 0;
   int          pop_tot = 0;
   bit          quiet = 1'b0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data = '0;
   beat_t       exp_q[$];
   logic [13:0] addr_q[$];
   bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ a[13:6] ^ 8'h5A;
   endfunction

   function automatic logic [PA_W-1:0] mem_pa(input logic [ADDR_W-1:0] a);
      return a[9:0] ^ 10'h155;
   endfunction

   // BRAM model: one-cycle read latency
   always @(posedge clk) begin
      if (rden_o) begin
         rdata_i    <= mem_data(rdptr_o);
         pa_rdata_i <= mem_pa(rdptr_o);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      beat_t       b;
      logic [31:0] exp_addr;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (rden_o) begin
            iss_tot++;
            chk("rdptr_expected", 32'(addr_q.size() != 0), 32'd1);
            if (addr_q.size() != 0) chk("rdptr", 32'(rdptr_o), 32'(addr_q.pop_front()));
         end
         if (prev_stall) begin
            chk("hold_valid", 32'(m_valid_o), 32'd1);
            chk("hold_data", 32'(m_data_o), 32'(prev_data));
         end
         if (m_valid_o && m_ready_i) begin
            pop_tot++;
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               b = exp_q.pop_front();
`ifdef POOL_RD_ADDR_EN
               exp_addr = 32'(b.addr);
`else
               exp_addr = 32'd0;
`endif
               chk("beat_data", 32'(m_data_o), 32'(b.data));
               chk("beat_last", 32'(m_last_o), 32'(b.last));
               chk("beat_addr", 32'(m_addr_o), exp_addr);
            end
         end
         if (rden_o) chk("outstanding_le2", 32'((iss_tot - pop_tot) <= 2), 32'd1);
         if (done_o) done_cnt++;
         if (quiet) begin
            chk("quiet_rden", 32'(rden_o), 32'd0);
            chk("quiet_valid", 32'(m_valid_o), 32'd0);
         end
         prev_stall = m_valid_o && !m_ready_i;
         prev_data  = m_data_o;
      end
   end

   task automatic pulse(input logic [LANES-1:0] lanes);
      pool_last_i = lanes;
      @(posedge clk); #1;
      pool_last_i = '0;
   endtask

   task automatic start_xfer(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len,
                             input logic [LANES-1:0] mask);
      logic [ADDR_W-1:0] a;
      for (int i = 0; i < int'(len); i++) begin
         a = base + ADDR_W'(i);
         addr_q.push_back(a);
         exp_q.push_back('{mem_data(a), mem_pa(a), (i == int'(len) - 1)});
      end
      base_addr_i = base;
      len_i       = len;
      lane_mask_i = mask;
      start_i     = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_rden(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (rden_o) ok = 1'b1;
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (done_o) ok = 1'b1;
      end
      chk(tag, 32'(ok), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rden"}, 32'(rden_o), 32'd0);
      chk({tag, "_rdptr"}, 32'(rdptr_o), 32'd0);
      chk({tag, "_valid"}, 32'(m_valid_o), 32'd0);
      chk({tag, "_data"}, 32'(m_data_o), 32'd0);
      chk({tag, "_addr"}, 32'(m_addr_o), 32'd0);
      chk({tag, "_last"}, 32'(m_last_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
   endtask

   initial begin
      int d0;
      rst_n       = 1'b0;
      start_i     = 1'b0;
      base_addr_i = '0;
      len_i       = '0;
      lane_mask_i = '0;
      pool_last_i = '0;
      rdata_i     = '0;
      pa_rdata_i  = '0;
      m_ready_i   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // T1: all lanes already done, back-to-back stream
      pulse(16'hFFFF);
      start_xfer(14'h0100, 14'd4, 16'hFFFF);
      wait_rden("t1_rden_seen");
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         chk("t1_rden", 32'(rden_o), 32'(i < 4));
         chk("t1_valid", 32'(m_valid_o), 32'(i >= 2));
         chk("t1_last", 32'(m_last_o), 32'(i == 5));
      end
      @(negedge clk);
      chk("t1_done", 32'(done_o), 32'd1);
      @(negedge clk);
      chk("t1_done_pulse", 32'(done_o), 32'd0);
      chk("t1_idle", 32'(busy_o), 32'd0);
      chk("t1_drained", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;

      // T2: wait for lane1 ten cycles after lane0
      start_xfer(14'h0020, 14'd2, 16'h0003);
      pulse(16'h0001);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2_rden_hold", 32'(rden_o), 32'd0);
         @(posedge clk); #1;
      end
      pool_last_i = 16'h0002;
      @(negedge clk);
      chk("t2_rden_pulse_cycle", 32'(rden_o), 32'd0);
      @(posedge clk); #1;
      pool_last_i = '0;
      @(negedge clk);
      chk("t2_rden_sticky_cycle", 32'(rden_o), 32'd0);
      @(negedge clk);
      chk("t2_rden_go", 32'(rden_o), 32'd1);
      wait_done("t2_done");
      chk("t2_drained", 32'(exp_q.size()), 32'd0);

      // T3: backpressure 1,0,0,1
      pulse(16'hFFFF);
      start_xfer(14'h0200, 14'd6, 16'hFFFF);
      d0 = done_cnt;
      for (int i = 0; i < 80 && done_cnt == d0; i++) begin
         m_ready_i = pat[i % 4];
         @(posedge clk); #1;
      end
      m_ready_i = 1'b1;
      chk("t3_done", 32'(done_cnt - d0), 32'd1);
      chk("t3_drained", 32'(exp_q.size()), 32'd0);
      chk("t3_addrs", 32'(addr_q.size()), 32'd0);

      // T4: address wrap
      pulse(16'hFFFF);
      start_xfer(14'h3FFE, 14'd4, 16'hFFFF);
      wait_done("t4_done");
      chk("t4_drained", 32'(exp_q.size()), 32'd0);
      chk("t4_addrs", 32'(addr_q.size()), 32'd0);

      // T5: zero length
      quiet = 1'b1;
      d0 = done_cnt;
      start_xfer(14'h0300, 14'd0, 16'h0000);
      wait_done("t5_done");
      repeat (4) @(posedge clk);
      #1;
      quiet = 1'b0;
      chk("t5_done_once", 32'(done_cnt - d0), 32'd1);
      @(negedge clk);
      chk("t5_idle", 32'(busy_o), 32'd0);
      @(posedge clk); #1;

      // T6: reset mid-READ, then a clean transfer
      pulse(16'hFFFF);
      start_xfer(14'h0400, 14'd8, 16'hFFFF);
      wait_rden("t6_rden_seen");
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_all_zero("t6_abort");
      exp_q.delete();
      addr_q.delete();
      iss_tot = 0;
      pop_tot = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      pulse(16'hFFFF);
      start_xfer(14'h0500, 14'd3, 16'hFFFF);
      wait_done("t6_done");
      chk("t6_drained", 32'(exp_q.size()), 32'd0);
      chk("t6_addrs", 32'(addr_q.size()), 32'd0);
      @(negedge clk);
      chk("t6_idle", 32'(busy_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
